ad_sched: RTL and testbench
===========================

Name: ad_sched

Overview:
Sequencing and merging controller for the eight ad_top channels.
- Issues periodic per-channel sample-start pulses, timed from pluse_us.
- Captures each channel's ad_data/ad_vld into a one-deep holding slot.
- Round-robin arbitrates the slots onto a single valid/ready sample stream for the downstream packer.
- Configured and monitored as an fx bus slave alongside control_top and ad_top.

Parameters:
NCH, 8, number of AD channels (register map fixed for 8)
PER_RST, 16'd1000, reset value of the sample period in microseconds

Ports:
clk_sys  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
pluse_us  input  1  one-clk_sys-cycle pulse every 1 us
dev_id  input  6  fx slave device id, compared to fx_waddr/fx_raddr[21:16]
fx_wr  input  1  fx write strobe
fx_waddr  input  22  fx write address; [7:0] = register offset
fx_data  input  8  fx write data
fx_rd  input  1  fx read strobe
fx_raddr  input  22  fx read address
fx_q  output  8  fx read data; 0 when not addressed (bus is OR-combined)
ad_start  output  8  per-channel one-cycle conversion start pulse
ad_vld  input  8  per-channel sample valid, one cycle per sample
ad_data  input  128  channel i sample on [16i+15:16i]
out_vld  output  1  merged sample valid
out_rdy  input  1  downstream ready
out_data  output  16  merged sample
out_ch  output  3  channel index of out_data

Behaviour:
- Reset values:
  - Outputs: fx_q=0, ad_start=0, out_vld=0, out_data=0, out_ch=0.
  - Registers: en_mask=8'h00, period=PER_RST, run=0, ovf=0, all slots empty, rr pointer=0, us counter=0.
- Register map (offset = addr[7:0], selected when addr[21:16]==dev_id):
  - 0x00 en_mask (RW)
  - 0x01 period[7:0] (RW)
  - 0x02 period[15:8] (RW)
  - 0x03 ctrl: bit0=run (RW), other bits read 0
  - 0x04 ovf[7:0] (R; write-1-to-clear per bit)
  - Other offsets: read 0, writes ignored.
- fx read: fx_q registered; valid the cycle after fx_rd; 0 in every cycle without an addressed read.
- fx write: takes effect at the edge where fx_wr is sampled.
- Timer:
  - When run=1 and period!=0, count pluse_us pulses.
  - When the count reaches period-1 and pluse_us=1: count returns to 0 and ad_start=en_mask for exactly one cycle (the next cycle).
  - run=0 or period=0: counter held at 0, no ad_start.
  - Any write to 0x01/0x02/0x03: counter cleared to 0.
  - First tick after run rises occurs period us later.
- Capture:
  - ad_vld[i]=1 with en_mask[i]=1 and slot i empty: slot loads ad_data[i], pending[i]=1.
  - Disabled channels' ad_vld ignored.
  - ad_vld[i] while slot i pending and not granted this cycle: new sample dropped, old sample kept, ovf[i] set.
  - Slot granted in the same cycle as a new ad_vld[i]: reload, no overflow.
  - Simultaneous set and W1C of the same ovf bit: set wins.
- Arbitration:
  - Output register may load when out_vld=0, or out_vld&out_rdy (taken this cycle).
  - Grant goes to the first pending slot searching from rr pointer upward, modulo 8.
  - On grant of channel g: out_data/out_ch/out_vld load, pending[g] clears, rr pointer=g+1 mod 8.
  - No pending slot when the output is taken: out_vld=0 next cycle.
- Handshake: out_data/out_ch held stable while out_vld=1 and out_rdy=0. Back-to-back transfers sustain 1 sample/cycle.
- Latency: ad_vld at edge k gives pending at k; out_vld rises after edge k+1 if the output is free.
- Clearing en_mask[i] does not flush an already-pending slot i; it still drains.
- rst mid-operation: all state returns to reset values in the next cycle, pending samples discarded.

Test Plan:
- Config readback: write 0x00=8'hA5, 0x01=8'hE8, 0x02=8'h03, 0x03=1, read each back -> fx_q=A5, E8, 03, 01 one cycle after fx_rd; read with wrong dev_id -> fx_q=0.
- Timer: en_mask=8'h0F, period=3, run=1, pluse_us every 10 cycles -> ad_start=8'h0F one cycle every 30 cycles, first pulse 3 us after run write; run=0 -> no further pulses.
- Round robin: out_rdy=1, ad_vld=8'hFF in one cycle with data 16'h1000+i -> out_ch 0..7 on consecutive cycles, data 1000..1007; next burst after a last grant to ch3 starts at ch4.
- Backpressure: out_rdy=0 for 20 cycles, ch2 ad_vld twice (data 0x0111, then 0x0222) -> out_data holds the first granted sample stable, ovf=8'h04, slot keeps 0x0111; write 0x04=8'h04 -> ovf=0.
- Same-cycle reload: ch5 pending granted while ad_vld[5]=1 -> both samples emitted, ovf[5]=0; disabled ch6 ad_vld -> nothing emitted.
- Reset mid-burst: rst=1 for one cycle with 4 slots pending and out_vld=1 -> out_vld=0, ad_start=0, ovf=0, en_mask=0, period=PER_RST next cycle.

Source files
------------

// File: rtl/ad_sched_if.sv
// Bus bundle for ad_sched: fx slave port, per-channel AD strobes/data and the
// merged sample stream.
interface ad_sched_if #(
  parameter int NCH = 8
);
  logic                 fx_wr;
  logic [21:0]          fx_waddr;
  logic [7:0]           fx_data;
  logic                 fx_rd;
  logic [21:0]          fx_raddr;
  logic [7:0]           fx_q;
  logic [NCH-1:0]       ad_start;
  logic [NCH-1:0]       ad_vld;
  logic [16*NCH-1:0]    ad_data;
  logic                 out_vld;
  logic                 out_rdy;
  logic [15:0]          out_data;
  logic [$clog2(NCH)-1:0] out_ch;

  modport slave (
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, ad_vld, ad_data, out_rdy,
    output fx_q, ad_start, out_vld, out_data, out_ch
  );
  modport master (
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, ad_vld, ad_data, out_rdy,
    input  fx_q, ad_start, out_vld, out_data, out_ch
  );
endinterface

// File: rtl/ad_sched.sv
// AD channel sequencer: periodic start pulses, one-deep per-channel holding
// slots, round-robin merge onto a valid/ready stream, fx slave registers.

module ad_sched_slot (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        cap_i,
  input  logic        gnt_i,
  input  logic [15:0] din_i,
  output logic        pend_o,
  output logic [15:0] data_o,
  output logic        ovf_o
);
  logic        pend_q;
  logic [15:0] data_q;

  // A grant frees the slot in the same cycle, so a coincident sample reloads it.
  assign ovf_o  = cap_i & pend_q & ~gnt_i;
  assign pend_o = pend_q;
  assign data_o = data_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else if (cap_i && (!pend_q || gnt_i)) begin
      pend_q <= 1'b1;
      data_q <= din_i;
    end else if (gnt_i) begin
      pend_q <= 1'b0;
    end
  end
endmodule

module ad_sched #(
  parameter int          NCH     = 8,
  parameter logic [15:0] PER_RST = 16'd1000
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          pluse_us,
  input  logic [5:0]    dev_id,
  ad_sched_if.slave     bus
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]        en_mask_q;
  logic [15:0]           period_q;
  logic                  run_q;
  logic [NCH-1:0]        ovf_q, ovf_d, ovf_set;
  logic [15:0]           cnt_q, cnt_d;
  logic                  tick;
  logic [NCH-1:0]        ad_start_q;
  logic [7:0]            fx_q_q, rd_val;
  logic [CW-1:0]         rr_q;
  logic                  out_vld_q;
  logic [15:0]           out_data_q;
  logic [CW-1:0]         out_ch_q;

  logic                  wr_sel, rd_sel, cfg_wr;
  logic [7:0]            woff;
  logic [NCH-1:0][15:0]  din, slot_data;
  logic [NCH-1:0]        cap, pend, gnt;
  logic                  load_out, gnt_vld;
  logic [CW-1:0]         gnt_ch;

  assign wr_sel = bus.fx_wr && (bus.fx_waddr[21:16] == dev_id);
  assign rd_sel = bus.fx_rd && (bus.fx_raddr[21:16] == dev_id);
  assign woff   = bus.fx_waddr[7:0];
  assign cfg_wr = wr_sel && (woff == 8'h01 || woff == 8'h02 || woff == 8'h03);

  assign din = bus.ad_data;
  assign cap = bus.ad_vld & en_mask_q;

  ad_sched_slot u_slot [NCH-1:0] (
    .clk_sys (clk_sys),
    .rst     (rst),
    .cap_i   (cap),
    .gnt_i   (gnt),
    .din_i   (din),
    .pend_o  (pend),
    .data_o  (slot_data),
    .ovf_o   (ovf_set)
  );

  // Round-robin search from rr_q; the downward loop leaves the nearest hit.
  always_comb begin
    logic [CW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      idx = rr_q + k[CW-1:0];
      if (pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx;
      end
    end
  end

  assign load_out = !out_vld_q || bus.out_rdy;
  assign gnt      = (load_out && gnt_vld) ? (NCH'(1) << gnt_ch) : '0;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (cfg_wr || !run_q || period_q == 16'd0) begin
      cnt_d = '0;
    end else if (pluse_us) begin
      if (cnt_q == period_q - 16'd1) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Hardware set outranks a coincident write-1-to-clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_sel && woff == 8'h04) ovf_d = ovf_d & ~bus.fx_data[NCH-1:0];
    ovf_d = ovf_d | ovf_set;
  end

  always_comb begin
    case (bus.fx_raddr[7:0])
      8'h00:   rd_val = en_mask_q;
      8'h01:   rd_val = period_q[7:0];
      8'h02:   rd_val = period_q[15:8];
      8'h03:   rd_val = {7'd0, run_q};
      8'h04:   rd_val = ovf_q;
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      en_mask_q  <= '0;
      period_q   <= PER_RST;
      run_q      <= 1'b0;
      ovf_q      <= '0;
      cnt_q      <= '0;
      ad_start_q <= '0;
      fx_q_q     <= '0;
      rr_q       <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      if (wr_sel) begin
        case (woff)
          8'h00:   en_mask_q      <= bus.fx_data[NCH-1:0];
          8'h01:   period_q[7:0]  <= bus.fx_data;
          8'h02:   period_q[15:8] <= bus.fx_data;
          8'h03:   run_q          <= bus.fx_data[0];
          default: ;
        endcase
      end
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      ad_start_q <= tick ? en_mask_q : '0;
      fx_q_q     <= rd_sel ? rd_val : 8'h00;
      if (load_out) begin
        out_vld_q <= gnt_vld;
        if (gnt_vld) begin
          out_data_q <= slot_data[gnt_ch];
          out_ch_q   <= gnt_ch;
          rr_q       <= gnt_ch + CW'(1);
        end
      end
    end
  end

  assign bus.fx_q     = fx_q_q;
  assign bus.ad_start = ad_start_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.out_ch   = out_ch_q;
endmodule

// File: tb/tb_ad_sched.sv
// Directed bench for ad_sched: register access, timer, round robin,
// backpressure/overflow, same-cycle reload and mid-run reset.
module tb_ad_sched;
  localparam logic [5:0] DEV = 6'h15;

  logic       clk = 1'b0;
  logic       rst;
  logic       pluse_us;
  logic [5:0] dev_id;
  int         n_chk = 0;
  int         n_err = 0;

  ad_sched_if #(.NCH(8)) bus ();

  ad_sched #(.NCH(8), .PER_RST(16'd1000)) dut (
    .clk_sys  (clk),
    .rst      (rst),
    .pluse_us (pluse_us),
    .dev_id   (dev_id),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fxw(input logic [7:0] off, input logic [7:0] d);
    bus.fx_wr    = 1'b1;
    bus.fx_waddr = {DEV, 8'h00, off};
    bus.fx_data  = d;
    step();
    bus.fx_wr    = 1'b0;
  endtask

  task automatic fxr(input logic [5:0] id, input logic [7:0] off, output logic [7:0] q);
    bus.fx_rd    = 1'b1;
    bus.fx_raddr = {id, 8'h00, off};
    step();
    bus.fx_rd    = 1'b0;
    q            = bus.fx_q;
  endtask

  task automatic set_data(input int ch, input logic [15:0] d);
    bus.ad_data[16*ch +: 16] = d;
  endtask

  // Fire one capture cycle, then expect cnt grants in ring order from first.
  task automatic burst(input logic [7:0] mask, input logic [15:0] base, input int first, input int cnt);
    for (int i = 0; i < 8; i++) set_data(i, base + 16'(i));
    bus.ad_vld = mask;
    step();
    bus.ad_vld = '0;
    for (int n = 0; n < cnt; n++) begin
      int ch;
      ch = (first + n) % 8;
      step();
      chk("rr_beat", {bus.out_vld, 5'd0, bus.out_ch, bus.out_data},
          {1'b1, 5'd0, 3'(ch), base + 16'(ch)});
    end
    step();
    chk("rr_idle", {31'd0, bus.out_vld}, 32'd0);
  endtask

  initial begin
    logic [7:0] q;
    int         npulse, first_j, last_val;

    rst = 1'b1; pluse_us = 1'b0; dev_id = DEV;
    bus.fx_wr = 1'b0; bus.fx_waddr = '0; bus.fx_data = '0;
    bus.fx_rd = 1'b0; bus.fx_raddr = '0;
    bus.ad_vld = '0; bus.ad_data = '0; bus.out_rdy = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_outs", {bus.fx_q, bus.ad_start, 7'd0, bus.out_vld, 5'd0, bus.out_ch},
        32'd0);
    chk("rst_odata", {16'd0, bus.out_data}, 32'd0);
    fxr(DEV, 8'h01, q); chk("rst_per_lo", {24'd0, q}, 32'hE8);
    fxr(DEV, 8'h02, q); chk("rst_per_hi", {24'd0, q}, 32'h03);
    fxr(DEV, 8'h00, q); chk("rst_mask", {24'd0, q}, 32'h00);

    // Register readback
    fxw(8'h00, 8'hA5); fxw(8'h01, 8'hE8); fxw(8'h02, 8'h03); fxw(8'h03, 8'h01);
    fxr(DEV, 8'h00, q); chk("rb_mask", {24'd0, q}, 32'hA5);
    fxr(DEV, 8'h01, q); chk("rb_per_lo", {24'd0, q}, 32'hE8);
    fxr(DEV, 8'h02, q); chk("rb_per_hi", {24'd0, q}, 32'h03);
    fxr(DEV, 8'h03, q); chk("rb_ctrl", {24'd0, q}, 32'h01);
    step();              chk("fxq_idle", {24'd0, bus.fx_q}, 32'h00);
    fxr(6'h2A, 8'h00, q); chk("rb_wrong_id", {24'd0, q}, 32'h00);
    fxr(DEV, 8'h07, q);   chk("rb_unmapped", {24'd0, q}, 32'h00);
    fxw(8'h03, 8'h00);

    // Timer: period 3 us, one us pulse every 10 cycles
    fxw(8'h00, 8'h0F); fxw(8'h01, 8'h03); fxw(8'h02, 8'h00); fxw(8'h03, 8'h01);
    npulse = 0; first_j = -1; last_val = 0;
    for (int j = 0; j < 100; j++) begin
      pluse_us = (j % 10 == 9);
      step();
      if (bus.ad_start != 8'h00) begin
        if (first_j < 0) first_j = j;
        npulse++;
        last_val = int'(bus.ad_start);
      end
    end
    pluse_us = 1'b0;
    chk("tmr_count", 32'(npulse), 32'd3);
    chk("tmr_first", 32'(first_j), 32'd29);
    chk("tmr_value", 32'(last_val), 32'h0F);
    fxw(8'h03, 8'h00);
    npulse = 0;
    for (int j = 0; j < 50; j++) begin
      pluse_us = (j % 10 == 9);
      step();
      if (bus.ad_start != 8'h00) npulse++;
    end
    pluse_us = 1'b0;
    chk("tmr_stopped", 32'(npulse), 32'd0);

    // Round robin
    fxw(8'h00, 8'hFF);
    bus.out_rdy = 1'b1;
    burst(8'hFF, 16'h1000, 0, 8);
    burst(8'h0F, 16'h1100, 0, 4);
    burst(8'hFF, 16'h2000, 4, 8);

    // Backpressure and overflow
    bus.out_rdy = 1'b0;
    set_data(0, 16'h0AAA); bus.ad_vld = 8'h01; step(); bus.ad_vld = '0;
    step();
    chk("bp_first", {bus.out_vld, 15'd0, bus.out_data}, {1'b1, 15'd0, 16'h0AAA});
    set_data(2, 16'h0111); bus.ad_vld = 8'h04; step(); bus.ad_vld = '0;
    step();
    set_data(2, 16'h0222); bus.ad_vld = 8'h04; step(); bus.ad_vld = '0;
    for (int j = 0; j < 15; j++) begin
      step();
      chk("bp_hold", {bus.out_vld, 12'd0, bus.out_ch, bus.out_data},
          {1'b1, 12'd0, 3'd0, 16'h0AAA});
    end
    fxr(DEV, 8'h04, q); chk("bp_ovf", {24'd0, q}, 32'h04);
    fxw(8'h04, 8'h04);
    fxr(DEV, 8'h04, q); chk("bp_ovf_clr", {24'd0, q}, 32'h00);
    bus.out_rdy = 1'b1;
    step();
    chk("bp_drain", {bus.out_vld, 12'd0, bus.out_ch, bus.out_data},
        {1'b1, 12'd0, 3'd2, 16'h0111});
    step();
    chk("bp_empty", {31'd0, bus.out_vld}, 32'd0);

    // Same-cycle reload on ch5
    set_data(5, 16'h0555); bus.ad_vld = 8'h20; step();
    set_data(5, 16'h0556); step();
    bus.ad_vld = '0;
    chk("rl_a", {bus.out_vld, 12'd0, bus.out_ch, bus.out_data}, {1'b1, 12'd0, 3'd5, 16'h0555});
    step();
    chk("rl_b", {bus.out_vld, 12'd0, bus.out_ch, bus.out_data}, {1'b1, 12'd0, 3'd5, 16'h0556});
    step();
    chk("rl_end", {31'd0, bus.out_vld}, 32'd0);
    fxr(DEV, 8'h04, q); chk("rl_ovf", {24'd0, q}, 32'h00);
    fxw(8'h00, 8'hBF);
    set_data(6, 16'h0666); bus.ad_vld = 8'h40; step(); bus.ad_vld = '0;
    npulse = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      if (bus.out_vld) npulse++;
    end
    chk("dis_ch6", 32'(npulse), 32'd0);

    // Reset mid-burst
    fxw(8'h00, 8'hFF); fxw(8'h01, 8'h05);
    bus.out_rdy = 1'b0;
    burst_fill: begin
      for (int i = 0; i < 8; i++) set_data(i, 16'h3000 + 16'(i));
      bus.ad_vld = 8'h1F; step(); bus.ad_vld = '0;
    end
    step();
    chk("mid_busy", {bus.out_vld, 28'd0, bus.out_ch}, {1'b1, 28'd0, 3'd0});
    bus.ad_vld = 8'h02; step(); bus.ad_vld = '0;
    fxr(DEV, 8'h04, q); chk("mid_ovf", {24'd0, q}, 32'h02);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_outs", {bus.ad_start, 23'd0, bus.out_vld}, 32'd0);
    fxr(DEV, 8'h00, q); chk("mid_mask", {24'd0, q}, 32'h00);
    fxr(DEV, 8'h01, q); chk("mid_per_lo", {24'd0, q}, 32'hE8);
    fxr(DEV, 8'h02, q); chk("mid_per_hi", {24'd0, q}, 32'h03);
    fxr(DEV, 8'h04, q); chk("mid_ovf_rst", {24'd0, q}, 32'h00);
    bus.out_rdy = 1'b1;
    npulse = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      if (bus.out_vld) npulse++;
    end
    chk("mid_discard", 32'(npulse), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
